load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter SHALL be: MAX_WAIT, default 255, maximum cycles spent in REQ or WAIT before a bus-timeout error.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
REQ-004 start_valid  input  1  upstream presents a memory operation.
REQ-005 start_ready  output  1  unit can accept; equals (state==IDLE) && rst_n.
REQ-006 is_load, is_store  input  1 each  opcode class (0000011 / 0100011).
REQ-007 funct3  input  3  width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 rs1_val, rs2_val, imm  input  32 each  base, store data, sign-extended immediate.
REQ-009 rd_idx  input  5  destination register of a load.
REQ-010 mem_req, mem_we  output  1 each  bus request and write enable.
REQ-011 mem_addr  output  32  word-aligned address {ea[31:2],2'b00}; mem_wdata output 32; mem_wstrb output 4.
REQ-012 mem_gnt, mem_rvalid  input  1 each  request accepted; read data valid.
REQ-013 mem_rdata  input  32  read data word.
REQ-014 done_valid, done_err, wb_en  output  1 each  completion pulse, error flag, register write enable.
REQ-015 wb_rd  output  5; wb_data  output  32  load writeback.

Function
REQ-016 On start_valid && start_ready, the unit SHALL latch all inputs and compute ea = rs1_val + imm (mod 2^32).
REQ-017 States SHALL be IDLE, REQ, WAIT, DONE; IDLE->REQ on accept unless an error is detected at accept, in which case IDLE->DONE with done_err=1.
REQ-018 Errors detected at accept: H/HU with ea[0]=1; W with ea[1:0]!=0; is_store with funct3 other than 000/001/010; is_load with funct3 of 011, 110 or 111; is_load==is_store.
REQ-019 In REQ, mem_req SHALL be 1 and mem_addr/mem_we/mem_wdata/mem_wstrb SHALL be stable until the cycle with mem_gnt=1.
REQ-020 REQ with mem_gnt: load->WAIT, store->DONE; mem_req SHALL be 0 the following cycle.
REQ-021 WAIT with mem_rvalid: capture mem_rdata, ->DONE; mem_rvalid outside WAIT SHALL be ignored.
REQ-022 Load extraction: lane=ea[1:0]; B/BU select byte mem_rdata[8*lane+7:8*lane], H/HU select half mem_rdata[16*ea[1]+15:16*ea[1]]; B/H sign-extend, BU/HU zero-extend, W passes the word.
REQ-023 Store: SB wdata={4{rs2[7:0]}}, wstrb=4'b0001<<ea[1:0]; SH wdata={2{rs2[15:0]}}, wstrb=4'b0011<<ea[1:0]; SW wdata=rs2, wstrb=4'b1111.
REQ-024 Timeout counter SHALL clear on entry to REQ and to WAIT and increment each cycle spent there; at count==MAX_WAIT it SHALL go to DONE with done_err=1 and mem_req=0.
REQ-025 DONE SHALL last exactly one cycle with done_valid=1, then ->IDLE; wb_en=1 only for a load with done_err=0.
REQ-026 Latency: store with immediate grant, accept at N, mem_req at N+1, done_valid at N+2; load with rvalid one cycle after grant, done_valid at N+3.
REQ-027 Outputs SHALL be registered, except start_ready; done_err, wb_en and wb_data SHALL be 0 whenever done_valid=0.

Reset
REQ-028 While rst_n=0 at a clock edge, the unit SHALL go to IDLE, clear the counter, and drive mem_req, mem_we, mem_wstrb, mem_addr, mem_wdata, done_valid, done_err, wb_en, wb_rd and wb_data to 0.
REQ-029 Reset asserted in REQ or WAIT SHALL abandon the operation with no done_valid pulse; a later mem_rvalid SHALL be ignored.

Verification
REQ-030 LW: rs1=0x1000, imm=4, mem_gnt immediate, rdata=0xDEADBEEF one cycle later -> mem_addr=0x1004, done_valid at N+3, wb_en=1, wb_data=0xDEADBEEF.
REQ-031 LB vs LBU: ea=0x2003, rdata=0x80112233 -> LB wb_data=0xFFFFFF80, LBU wb_data=0x00000080.
REQ-032 SH: rs1=0x3000, imm=2, rs2=0x0000ABCD -> mem_wdata=0xABCDABCD, mem_wstrb=4'b1100, mem_we=1, done_valid at N+2, wb_en=0.
REQ-033 LW with ea=0x1002 -> no mem_req, done_valid=1 and done_err=1 at N+1.
REQ-034 MAX_WAIT=4, mem_gnt held 0 -> mem_req high for 4 cycles, then done_err=1, mem_req=0.
REQ-035 rst_n=0 while in WAIT -> next cycle IDLE, start_ready=1 after release, no done_valid, stray mem_rvalid ignored.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: takes one RV32 memory operation at a time, issues a single
// bus request, and reports completion with optional load writeback.
module load_store_unit #(
   parameter int unsigned MAX_WAIT = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start_valid,
   output logic        start_ready,
   input  logic        is_load,
   input  logic        is_store,
   input  logic [2:0]  funct3,
   input  logic [31:0] rs1_val,
   input  logic [31:0] rs2_val,
   input  logic [31:0] imm,
   input  logic [4:0]  rd_idx,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   output logic        done_valid,
   output logic        done_err,
   output logic        wb_en,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data,
   output logic [1:0]  dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_DONE = 2'd3
   } state_t;

   localparam int unsigned CW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);
   localparam logic [CW-1:0] CNT_LAST = CW'(MAX_WAIT - 1);

   state_t      state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]  lane_q, lane_d;
   logic [2:0]  funct3_q, funct3_d;
   logic [4:0]  rd_q, rd_d;
   logic        mem_req_q, mem_req_d;
   logic        mem_we_q, mem_we_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic [3:0]  mem_wstrb_q, mem_wstrb_d;
   logic        done_valid_q, done_valid_d;
   logic        done_err_q, done_err_d;
   logic        wb_en_q, wb_en_d;
   logic [4:0]  wb_rd_q, wb_rd_d;
   logic [31:0] wb_data_q, wb_data_d;

   logic        accept;
   logic [31:0] ea_in;
   logic        misaligned, bad_funct3, acc_err;
   logic [31:0] st_wdata;
   logic [3:0]  st_wstrb;
   logic [31:0] ld_data;

   assign start_ready = (state_q == S_IDLE) && rst_n;
   assign accept      = start_valid && start_ready;

   // Accept-time decode: effective address, error classification, store lanes.
   always_comb begin
      ea_in      = rs1_val + imm;
      misaligned = 1'b0;
      bad_funct3 = 1'b0;
      st_wdata   = 32'd0;
      st_wstrb   = 4'd0;
      case (funct3)
         3'b001, 3'b101: misaligned = ea_in[0];
         3'b010:         misaligned = |ea_in[1:0];
         default:        misaligned = 1'b0;
      endcase
      if (is_store && !(funct3 == 3'b000 || funct3 == 3'b001 || funct3 == 3'b010))
         bad_funct3 = 1'b1;
      if (is_load && (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111))
         bad_funct3 = 1'b1;
      acc_err = (is_load == is_store) || bad_funct3 || misaligned;
      if (is_store) begin
         case (funct3[1:0])
            2'b00: begin
               st_wdata = {4{rs2_val[7:0]}};
               st_wstrb = 4'b0001 << ea_in[1:0];
            end
            2'b01: begin
               st_wdata = {2{rs2_val[15:0]}};
               st_wstrb = 4'b0011 << ea_in[1:0];
            end
            default: begin
               st_wdata = rs2_val;
               st_wstrb = 4'b1111;
            end
         endcase
      end
   end

   always_comb begin
      case (funct3_q)
         3'b000:  ld_data = {{24{mem_rdata[{lane_q, 3'b000} + 7]}}, mem_rdata[{lane_q, 3'b000} +: 8]};
         3'b100:  ld_data = {24'd0, mem_rdata[{lane_q, 3'b000} +: 8]};
         3'b001:  ld_data = {{16{mem_rdata[{lane_q[1], 4'b0000} + 15]}}, mem_rdata[{lane_q[1], 4'b0000} +: 16]};
         3'b101:  ld_data = {16'd0, mem_rdata[{lane_q[1], 4'b0000} +: 16]};
         default: ld_data = mem_rdata;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      lane_d       = lane_q;
      funct3_d     = funct3_q;
      rd_d         = rd_q;
      mem_req_d    = 1'b0;
      mem_we_d     = 1'b0;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      mem_wstrb_d  = mem_wstrb_q;
      done_valid_d = 1'b0;
      done_err_d   = 1'b0;
      wb_en_d      = 1'b0;
      wb_rd_d      = 5'd0;
      wb_data_d    = 32'd0;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               lane_d   = ea_in[1:0];
               funct3_d = funct3;
               rd_d     = rd_idx;
               if (acc_err) begin
                  state_d      = S_DONE;
                  done_valid_d = 1'b1;
                  done_err_d   = 1'b1;
               end else begin
                  state_d     = S_REQ;
                  cnt_d       = '0;
                  mem_req_d   = 1'b1;
                  mem_we_d    = is_store;
                  mem_addr_d  = {ea_in[31:2], 2'b00};
                  mem_wdata_d = st_wdata;
                  mem_wstrb_d = st_wstrb;
               end
            end
         end
         S_REQ: begin
            // A grant in the final allowed cycle still wins over the timeout.
            if (mem_gnt) begin
               if (mem_we_q) begin
                  state_d      = S_DONE;
                  done_valid_d = 1'b1;
               end else begin
                  state_d = S_WAIT;
                  cnt_d   = '0;
               end
            end else if (cnt_q == CNT_LAST) begin
               state_d      = S_DONE;
               done_valid_d = 1'b1;
               done_err_d   = 1'b1;
            end else begin
               cnt_d     = cnt_q + 1'b1;
               mem_req_d = 1'b1;
               mem_we_d  = mem_we_q;
            end
         end
         S_WAIT: begin
            if (mem_rvalid) begin
               state_d      = S_DONE;
               done_valid_d = 1'b1;
               wb_en_d      = 1'b1;
               wb_rd_d      = rd_q;
               wb_data_d    = ld_data;
            end else if (cnt_q == CNT_LAST) begin
               state_d      = S_DONE;
               done_valid_d = 1'b1;
               done_err_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         lane_q       <= 2'd0;
         funct3_q     <= 3'd0;
         rd_q         <= 5'd0;
         mem_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= 32'd0;
         mem_wdata_q  <= 32'd0;
         mem_wstrb_q  <= 4'd0;
         done_valid_q <= 1'b0;
         done_err_q   <= 1'b0;
         wb_en_q      <= 1'b0;
         wb_rd_q      <= 5'd0;
         wb_data_q    <= 32'd0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         lane_q       <= lane_d;
         funct3_q     <= funct3_d;
         rd_q         <= rd_d;
         mem_req_q    <= mem_req_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         mem_wstrb_q  <= mem_wstrb_d;
         done_valid_q <= done_valid_d;
         done_err_q   <= done_err_d;
         wb_en_q      <= wb_en_d;
         wb_rd_q      <= wb_rd_d;
         wb_data_q    <= wb_data_d;
      end
   end

   assign mem_req    = mem_req_q;
   assign mem_we     = mem_we_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;
   assign mem_wstrb  = mem_wstrb_q;
   assign done_valid = done_valid_q;
   assign done_err   = done_err_q;
   assign wb_en      = wb_en_q;
   assign wb_rd      = wb_rd_q;
   assign wb_data    = wb_data_q;
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios plus back-to-back random
// operations against a behavioural model of the bus and latency rules.
module tb_load_store_unit;

   localparam int unsigned MW = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start_valid = 1'b0;
   logic        start_ready;
   logic        is_load = 1'b0, is_store = 1'b0;
   logic [2:0]  funct3 = 3'd0;
   logic [31:0] rs1_val = 32'd0, rs2_val = 32'd0, imm = 32'd0;
   logic [4:0]  rd_idx = 5'd0;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
   logic [31:0] mem_rdata = 32'd0;
   logic        done_valid, done_err, wb_en;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic [1:0]  dbg_state;

   load_store_unit #(.MAX_WAIT(MW)) dut (
      .clk(clk), .rst_n(rst_n),
      .start_valid(start_valid), .start_ready(start_ready),
      .is_load(is_load), .is_store(is_store), .funct3(funct3),
      .rs1_val(rs1_val), .rs2_val(rs2_val), .imm(imm), .rd_idx(rd_idx),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
      .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .done_valid(done_valid), .done_err(done_err), .wb_en(wb_en),
      .wb_rd(wb_rd), .wb_data(wb_data), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   logic [31:0] exp_q[$];

   // Observed result of the last run_op
   int          o_done_cyc, o_req_cyc, o_proto_bad;
   logic        o_err, o_wb_en, o_we;
   logic [4:0]  o_wb_rd;
   logic [31:0] o_wb_data, o_addr, o_wdata;
   logic [3:0]  o_wstrb;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drives one operation from IDLE and plays the memory: grant after g
   // request cycles, read data r cycles into the wait phase.
   task automatic run_op(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [31:0] im, input logic [4:0] rd,
                         input int g, input int r, input logic [31:0] rdata);
      int req_n = 0;
      int wait_n = 0;
      bit in_wait = 0;
      bit done = 0;
      o_done_cyc = -1; o_req_cyc = 0; o_proto_bad = 0;
      o_err = 0; o_wb_en = 0; o_we = 0; o_wb_rd = 0;
      o_wb_data = 0; o_addr = 0; o_wdata = 0; o_wstrb = 0;
      if (start_ready !== 1'b1) o_proto_bad++;
      start_valid = 1'b1; is_load = ld; is_store = st; funct3 = f3;
      rs1_val = rs1; rs2_val = rs2; imm = im; rd_idx = rd;
      tick();
      start_valid = 1'b0;
      is_load = 1'($urandom); is_store = 1'($urandom); funct3 = 3'($urandom);
      rs1_val = $urandom; rs2_val = $urandom; imm = $urandom; rd_idx = 5'($urandom);
      for (int c = 1; c <= 40 && !done; c++) begin
         mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
         if (done_valid === 1'b1) begin
            o_done_cyc = c; o_err = done_err; o_wb_en = wb_en;
            o_wb_rd = wb_rd; o_wb_data = wb_data; done = 1;
         end else if (done_err !== 1'b0 || wb_en !== 1'b0 || wb_data !== 32'd0) begin
            o_proto_bad++;
         end
         if (mem_req === 1'b1) begin
            if (req_n == 0) begin
               o_addr = mem_addr; o_we = mem_we; o_wdata = mem_wdata; o_wstrb = mem_wstrb;
            end else if (mem_addr !== o_addr || mem_we !== o_we ||
                         mem_wdata !== o_wdata || mem_wstrb !== o_wstrb) begin
               o_proto_bad++;
            end
            if (req_n == g) begin
               mem_gnt = 1'b1;
               if (ld) in_wait = 1;
            end
            req_n++;
         end else if (in_wait) begin
            if (wait_n == r) begin
               mem_rvalid = 1'b1; mem_rdata = rdata; in_wait = 0;
            end
            wait_n++;
         end
         if (!done) tick();
      end
      o_req_cyc = req_n;
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
      tick();
      if (done_valid !== 1'b0 || start_ready !== 1'b1) o_proto_bad++;
   endtask

   // Reference model: outcome of one operation from the architectural rules.
   task automatic model(input logic ld, input logic st, input logic [2:0] f3,
                        input logic [31:0] rs1, input logic [31:0] rs2,
                        input logic [31:0] im, input int g, input int r,
                        input logic [31:0] rdata,
                        output int e_done, output int e_req, output logic e_err,
                        output logic e_wb_en, output logic [31:0] e_addr,
                        output logic [31:0] e_wdata, output logic [3:0] e_wstrb,
                        output logic [31:0] e_data);
      logic [31:0] ea, v;
      int lane, size;
      bit legal;
      ea = rs1 + im;
      lane = int'(ea % 4);
      case (f3)
         3'b000, 3'b100: size = 1;
         3'b001, 3'b101: size = 2;
         3'b010:         size = 4;
         default:        size = 0;
      endcase
      legal = (ld != st) && (size != 0) && !(st && f3[2]) && ((ea % size) == 0);
      e_addr  = ea & 32'hFFFF_FFFC;
      e_wdata = (size == 1) ? rs2[7:0] * 32'h0101_0101 :
                (size == 2) ? rs2[15:0] * 32'h0001_0001 : rs2;
      e_wstrb = 4'(((1 << size) - 1) << lane);
      e_err = 0; e_wb_en = 0; e_data = 0; e_req = 0; e_done = 0;
      v = rdata >> (8 * lane);
      if (size == 1) v = ((f3 == 3'b000) && v[7]) ? (v | 32'hFFFF_FF00) : (v & 32'hFF);
      if (size == 2) v = ((f3 == 3'b001) && v[15]) ? (v | 32'hFFFF_0000) : (v & 32'hFFFF);
      if (!legal) begin
         e_done = 1; e_err = 1;
      end else if (g >= int'(MW)) begin
         e_req = MW; e_done = 1 + MW; e_err = 1;
      end else if (st) begin
         e_req = g + 1; e_done = g + 2;
      end else if (r >= int'(MW)) begin
         e_req = g + 1; e_done = g + 2 + MW; e_err = 1;
      end else begin
         e_req = g + 1; e_done = g + 3 + r; e_wb_en = 1; e_data = v;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick(); tick(); tick();
      n_checks++;
      if (start_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", start_ready); end
      n_checks++;
      if ({mem_req, mem_we, mem_wstrb, mem_addr, mem_wdata, done_valid, done_err, wb_en, wb_rd, wb_data} !== '0) begin
         n_fail++; $display("FAIL reset_outputs: got nonzero outputs addr=%h wdata=%h", mem_addr, mem_wdata);
      end
      rst_n = 1'b1;
      tick();
      n_checks++;
      if (start_ready !== 1'b1 || dbg_state !== 2'd0) begin
         n_fail++; $display("FAIL reset_release: ready=%b state=%0d want 1/0", start_ready, dbg_state);
      end
   endtask

   task automatic test_lw();
      run_op(1, 0, 3'b010, 32'h1000, 32'h0, 32'd4, 5'd7, 0, 0, 32'hDEAD_BEEF);
      n_checks++;
      if (o_addr !== 32'h1004 || o_we !== 1'b0) begin n_fail++; $display("FAIL lw_addr: got %h we=%b want 00001004 0", o_addr, o_we); end
      n_checks++;
      if (o_done_cyc !== 3) begin n_fail++; $display("FAIL lw_latency: got %0d want 3", o_done_cyc); end
      n_checks++;
      if (o_wb_en !== 1'b1 || o_err !== 1'b0 || o_wb_data !== 32'hDEAD_BEEF || o_wb_rd !== 5'd7) begin
         n_fail++; $display("FAIL lw_wb: en=%b err=%b data=%h rd=%0d want 1 0 deadbeef 7", o_wb_en, o_err, o_wb_data, o_wb_rd);
      end
      n_checks++;
      if (o_proto_bad !== 0) begin n_fail++; $display("FAIL lw_protocol: got %0d violations want 0", o_proto_bad); end
   endtask

   task automatic test_lb_lbu();
      run_op(1, 0, 3'b000, 32'h2000, 32'h0, 32'd3, 5'd1, 0, 0, 32'h8011_2233);
      n_checks++;
      if (o_wb_data !== 32'hFFFF_FF80 || o_addr !== 32'h2000) begin
         n_fail++; $display("FAIL lb_sext: got %h addr=%h want ffffff80 00002000", o_wb_data, o_addr);
      end
      run_op(1, 0, 3'b100, 32'h2000, 32'h0, 32'd3, 5'd2, 0, 0, 32'h8011_2233);
      n_checks++;
      if (o_wb_data !== 32'h0000_0080) begin n_fail++; $display("FAIL lbu_zext: got %h want 00000080", o_wb_data); end
   endtask

   task automatic test_sh();
      run_op(0, 1, 3'b001, 32'h3000, 32'h0000_ABCD, 32'd2, 5'd3, 0, 0, 32'h0);
      n_checks++;
      if (o_wdata !== 32'hABCD_ABCD || o_wstrb !== 4'b1100 || o_we !== 1'b1 || o_addr !== 32'h3000) begin
         n_fail++; $display("FAIL sh_bus: wdata=%h wstrb=%b we=%b addr=%h want abcdabcd 1100 1 00003000", o_wdata, o_wstrb, o_we, o_addr);
      end
      n_checks++;
      if (o_done_cyc !== 2 || o_wb_en !== 1'b0 || o_err !== 1'b0) begin
         n_fail++; $display("FAIL sh_done: cyc=%0d wb_en=%b err=%b want 2 0 0", o_done_cyc, o_wb_en, o_err);
      end
   endtask

   task automatic test_misaligned();
      run_op(1, 0, 3'b010, 32'h1000, 32'h0, 32'd2, 5'd4, 0, 0, 32'h1234_5678);
      n_checks++;
      if (o_req_cyc !== 0 || o_done_cyc !== 1 || o_err !== 1'b1 || o_wb_en !== 1'b0) begin
         n_fail++; $display("FAIL lw_misaligned: req=%0d cyc=%0d err=%b wb=%b want 0 1 1 0", o_req_cyc, o_done_cyc, o_err, o_wb_en);
      end
   endtask

   task automatic test_timeout();
      run_op(0, 1, 3'b010, 32'h40, 32'h5555_AAAA, 32'd0, 5'd0, 1000, 0, 32'h0);
      n_checks++;
      if (o_req_cyc !== 4 || o_done_cyc !== 5 || o_err !== 1'b1 || o_proto_bad !== 0) begin
         n_fail++; $display("FAIL req_timeout: req=%0d cyc=%0d err=%b bad=%0d want 4 5 1 0", o_req_cyc, o_done_cyc, o_err, o_proto_bad);
      end
      run_op(1, 0, 3'b010, 32'h80, 32'h0, 32'd0, 5'd9, 0, 1000, 32'h0);
      n_checks++;
      if (o_done_cyc !== 6 || o_err !== 1'b1 || o_wb_en !== 1'b0 || o_wb_data !== 32'd0) begin
         n_fail++; $display("FAIL wait_timeout: cyc=%0d err=%b wb=%b data=%h want 6 1 0 0", o_done_cyc, o_err, o_wb_en, o_wb_data);
      end
   endtask

   task automatic test_reset_in_wait();
      int stray_done = 0;
      start_valid = 1'b1; is_load = 1'b1; is_store = 1'b0; funct3 = 3'b010;
      rs1_val = 32'h500; imm = 32'd8; rd_idx = 5'd6;
      tick();
      start_valid = 1'b0;
      n_checks++;
      if (mem_req !== 1'b1) begin n_fail++; $display("FAIL rst_wait_req: got %b want 1", mem_req); end
      mem_gnt = 1'b1;
      tick();
      mem_gnt = 1'b0;
      rst_n = 1'b0;
      tick();
      n_checks++;
      if (start_ready !== 1'b0 || mem_req !== 1'b0 || done_valid !== 1'b0 || dbg_state !== 2'd0) begin
         n_fail++; $display("FAIL rst_wait_abandon: ready=%b req=%b done=%b state=%0d want 0 0 0 0", start_ready, mem_req, done_valid, dbg_state);
      end
      rst_n = 1'b1;
      mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
      tick();
      mem_rvalid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (done_valid !== 1'b0 || wb_en !== 1'b0) stray_done++;
         if (i < 4) tick();
      end
      n_checks++;
      if (stray_done !== 0 || start_ready !== 1'b1) begin
         n_fail++; $display("FAIL rst_wait_stray: done pulses=%0d ready=%b want 0 1", stray_done, start_ready);
      end
      run_op(1, 0, 3'b101, 32'h600, 32'h0, 32'd2, 5'd8, 1, 1, 32'h9876_5432);
      n_checks++;
      if (o_wb_data !== 32'h0000_9876 || o_done_cyc !== 5) begin
         n_fail++; $display("FAIL rst_wait_recover: data=%h cyc=%0d want 00009876 5", o_wb_data, o_done_cyc);
      end
   endtask

   task automatic test_back_to_back_random();
      logic ld, st;
      logic [2:0] f3;
      logic [31:0] rs1, rs2, im, rdata;
      logic [4:0] rd;
      int g, r, e_done, e_req;
      logic e_err, e_wb_en;
      logic [31:0] e_addr, e_wdata, e_data, exp_data;
      logic [3:0] e_wstrb;
      for (int n = 0; n < 150; n++) begin
         case ($urandom_range(0, 9))
            0:       begin ld = 1'($urandom); st = ld; end
            1,2,3,4: begin ld = 1'b0; st = 1'b1; end
            default: begin ld = 1'b1; st = 1'b0; end
         endcase
         f3    = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'($urandom_range(0, 2)) | (ld ? {$urandom_range(0, 1) == 1, 2'b00} : 3'b000);
         rs1   = $urandom;
         im    = 32'($signed(12'($urandom)));
         rs2   = $urandom;
         rd    = 5'($urandom);
         rdata = $urandom;
         g     = ($urandom_range(0, 7) == 0) ? $urandom_range(4, 6) : $urandom_range(0, 3);
         r     = ($urandom_range(0, 7) == 0) ? $urandom_range(4, 6) : $urandom_range(0, 3);
         model(ld, st, f3, rs1, rs2, im, g, r, rdata, e_done, e_req, e_err, e_wb_en, e_addr, e_wdata, e_wstrb, e_data);
         exp_q.push_back(e_data);
         run_op(ld, st, f3, rs1, rs2, im, rd, g, r, rdata);
         exp_data = exp_q.pop_front();
         n_checks++;
         if (o_done_cyc !== e_done || o_err !== e_err || o_req_cyc !== e_req) begin
            n_fail++; $display("FAIL rnd_timing[%0d]: cyc=%0d err=%b req=%0d want %0d %b %0d", n, o_done_cyc, o_err, o_req_cyc, e_done, e_err, e_req);
         end
         n_checks++;
         if (o_wb_en !== e_wb_en || o_wb_data !== exp_data || (e_wb_en && o_wb_rd !== rd)) begin
            n_fail++; $display("FAIL rnd_wb[%0d]: en=%b data=%h rd=%0d want %b %h %0d", n, o_wb_en, o_wb_data, o_wb_rd, e_wb_en, exp_data, rd);
         end
         if (e_req > 0) begin
            n_checks++;
            if (o_addr !== e_addr || o_we !== st || (st && (o_wdata !== e_wdata || o_wstrb !== e_wstrb))) begin
               n_fail++; $display("FAIL rnd_bus[%0d]: addr=%h we=%b wdata=%h wstrb=%b want %h %b %h %b", n, o_addr, o_we, o_wdata, o_wstrb, e_addr, st, e_wdata, e_wstrb);
            end
         end
         n_checks++;
         if (o_proto_bad !== 0) begin n_fail++; $display("FAIL rnd_protocol[%0d]: got %0d violations want 0", n, o_proto_bad); end
      end
   endtask

   initial begin
      test_reset();
      test_lw();
      test_lb_lbu();
      test_sh();
      test_misaligned();
      test_timeout();
      test_reset_in_wait();
      test_back_to_back_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
